// File: rtl/systolic_psum_drain.sv
// Systolic array bottom-edge sink: de-skews column psums, accumulates N beats per column, queues finished rows.
// Latency: NCOL cycles from the last column-0 beat of a group to out_vld, when a FIFO row is free.
// Backpressure: in_rdy drops between groups once DEPTH rows are claimed; out_vld/out_dat hold while out_rdy=0.
module systolic_psum_drain #(
    parameter int NCOL    = 4,
    parameter int TN      = 2,
    parameter int PSUM_DW = 20,
    parameter int ACC_DW  = 32,
    parameter int DEPTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic [15:0]                   cfg_num_acc,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [NCOL*TN*PSUM_DW-1:0]    col_psum,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [NCOL*TN*ACC_DW-1:0]     out_dat,
    output logic                          busy,
    output logic                          err_ovf
);

    localparam int LN = NCOL * TN;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic              take;
    logic              pop;
    logic              commit;
    logic              claim_inc;
    logic              mid_group;
    logic [NCOL-1:0]   vld_sr;
    logic [NCOL-1:0]   last;
    logic [NCOL-2:0]   vld_d;
    logic [15:0]       n_cfg;
    logic [15:0]       cnt  [NCOL];
    logic [PW-1:0]     wptr [NCOL];
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     claimed;
    logic [ACC_DW-1:0] psx  [LN];
    logic [ACC_DW-1:0] sum  [LN];
    logic [ACC_DW-1:0] acc  [LN];
    logic [ACC_DW-1:0] fifo [DEPTH][LN];

    // A group may always finish once started; a new group needs an unclaimed FIFO row.
    assign in_rdy    = (cnt[0] != 16'd0) | (claimed < CW'(DEPTH));
    assign take      = in_vld & in_rdy;
    assign pop       = out_vld & out_rdy;
    assign out_vld   = (count != '0);
    assign vld_sr    = {vld_d, take};
    assign commit    = last[NCOL-1];
    assign claim_inc = take & (cnt[0] == 16'd0);
    // Beats in flight count as busy so the group length cannot change under a wavefront.
    assign busy      = (|vld_sr) | mid_group | out_vld;

    // Per-lane sign extension and running sum; last beat of a group flagged per column.
    always_comb begin
        mid_group = 1'b0;
        last      = '0;
        for (int c = 0; c < NCOL; c++) begin
            mid_group = mid_group | (cnt[c] != 16'd0);
            last[c]   = vld_sr[c] & (cnt[c] == n_cfg - 16'd1);
            for (int t = 0; t < TN; t++) begin
                psx[c*TN+t] = ACC_DW'($signed(col_psum[(c*TN+t)*PSUM_DW +: PSUM_DW]));
                sum[c*TN+t] = (cnt[c] == 16'd0) ? psx[c*TN+t] : acc[c*TN+t] + psx[c*TN+t];
            end
        end
    end

    // Head row straight from storage, so a pop exposes the next row without a bubble.
    always_comb begin
        out_dat = '0;
        for (int l = 0; l < LN; l++) begin
            out_dat[l*ACC_DW +: ACC_DW] = fifo[rptr][l];
        end
    end

    // Skew chain, config latch, per-column beat counters, FIFO pointers, claim and error tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_d   <= '0;
            n_cfg   <= 16'd1;
            rptr    <= '0;
            count   <= '0;
            claimed <= '0;
            err_ovf <= 1'b0;
            for (int c = 0; c < NCOL; c++) begin
                cnt[c]  <= '0;
                wptr[c] <= '0;
            end
        end else if (clr) begin
            vld_d   <= '0;
            n_cfg   <= 16'd1;
            rptr    <= '0;
            count   <= '0;
            claimed <= '0;
            err_ovf <= 1'b0;
            for (int c = 0; c < NCOL; c++) begin
                cnt[c]  <= '0;
                wptr[c] <= '0;
            end
        end else begin
            vld_d <= vld_sr[NCOL-2:0];
            if (!busy) begin
                n_cfg <= (cfg_num_acc == 16'd0) ? 16'd1 : cfg_num_acc;
            end
            for (int c = 0; c < NCOL; c++) begin
                if (vld_sr[c]) begin
                    if (last[c]) begin
                        cnt[c]  <= '0;
                        wptr[c] <= (wptr[c] == PW'(DEPTH - 1)) ? '0 : wptr[c] + 1'b1;
                    end else begin
                        cnt[c] <= cnt[c] + 16'd1;
                    end
                end
            end
            if (pop) begin
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            if (commit & ~pop) begin
                count <= count + 1'b1;
            end else if (pop & ~commit) begin
                count <= count - 1'b1;
            end
            claimed <= claimed + CW'(claim_inc) - CW'(pop);
            if (in_vld & ~in_rdy) begin
                err_ovf <= 1'b1;
            end
        end
    end

    // Accumulator lanes and FIFO row storage; each column writes its own slice of the row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LN; l++) begin
                acc[l] <= '0;
                for (int d = 0; d < DEPTH; d++) fifo[d][l] <= '0;
            end
        end else if (clr) begin
            for (int l = 0; l < LN; l++) begin
                acc[l] <= '0;
                for (int d = 0; d < DEPTH; d++) fifo[d][l] <= '0;
            end
        end else begin
            for (int c = 0; c < NCOL; c++) begin
                for (int t = 0; t < TN; t++) begin
                    if (vld_sr[c]) acc[c*TN+t] <= sum[c*TN+t];
                    if (last[c])   fifo[wptr[c]][c*TN+t] <= sum[c*TN+t];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_psum_drain.sv
// Directed bench for systolic_psum_drain: single group, accumulation, wrap, back-pressure, streaming, reset.
// Latency: checks out_vld timing cycle by cycle against the NCOL-cycle de-skew.
// Backpressure: feeder honours in_rdy except where an overflow is forced on purpose.
module tb_systolic_psum_drain;

    localparam int NCOL = 4;
    localparam int TN   = 2;
    localparam int PDW  = 20;
    localparam int ADW  = 32;
    localparam int LN   = NCOL * TN;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clr = 1'b0;
    logic [15:0]         cfg_num_acc = 16'd1;
    logic                in_vld = 1'b0;
    logic                out_rdy = 1'b0;
    logic [LN*PDW-1:0]   col_psum;
    logic [LN*PDW-1:0]   pipe [NCOL];
    logic                in_rdy, out_vld, busy, err_ovf;
    logic [LN*ADW-1:0]   out_dat;
    logic                in_rdy_20, out_vld_20, busy_20, err_ovf_20;
    logic [LN*20-1:0]    out_dat_20;
    logic [LN*ADW-1:0]   rows_q [$];
    int                  n_cmp = 0;
    int                  n_bad = 0;

    systolic_psum_drain #(.NCOL(NCOL), .TN(TN), .PSUM_DW(PDW), .ACC_DW(ADW), .DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_num_acc(cfg_num_acc),
        .in_vld(in_vld), .in_rdy(in_rdy), .col_psum(col_psum),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
        .busy(busy), .err_ovf(err_ovf)
    );

    systolic_psum_drain #(.NCOL(NCOL), .TN(TN), .PSUM_DW(PDW), .ACC_DW(20), .DEPTH(2)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_num_acc(cfg_num_acc),
        .in_vld(in_vld), .in_rdy(in_rdy_20), .col_psum(col_psum),
        .out_vld(out_vld_20), .out_rdy(out_rdy), .out_dat(out_dat_20),
        .busy(busy_20), .err_ovf(err_ovf_20)
    );

    always #5 clk = ~clk;

    // Column c sees the beat that column 0 saw c cycles earlier.
    always_comb begin
        col_psum = '0;
        for (int c = 0; c < NCOL; c++) begin
            col_psum[c*TN*PDW +: TN*PDW] = pipe[c][c*TN*PDW +: TN*PDW];
        end
    end

    // Record every row the consumer takes.
    always @(negedge clk) begin
        if (out_vld && out_rdy) rows_q.push_back(out_dat);
    end

    function automatic logic [LN*PDW-1:0] beat(input int a, input int b, input int d);
        logic [LN*PDW-1:0] r;
        r = '0;
        for (int c = 0; c < NCOL; c++)
            for (int t = 0; t < TN; t++)
                r[(c*TN+t)*PDW +: PDW] = PDW'(a + b*c + d*t);
        return r;
    endfunction

    function automatic logic [LN*ADW-1:0] row(input int a, input int b, input int d);
        logic [LN*ADW-1:0] r;
        r = '0;
        for (int c = 0; c < NCOL; c++)
            for (int t = 0; t < TN; t++)
                r[(c*TN+t)*ADW +: ADW] = ADW'(a + b*c + d*t);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        for (int s = NCOL-1; s > 0; s--) pipe[s] = pipe[s-1];
    endtask

    task automatic send(input logic [LN*PDW-1:0] b);
        int w;
        w = 0;
        while (!in_rdy && w < 50) begin
            tick;
            w++;
        end
        if (!in_rdy) begin
            n_cmp++; n_bad++;
            $display("FAIL send_wait: in_rdy=%b after %0d cycles, want 1", in_rdy, w);
        end
        in_vld  = 1'b1;
        pipe[0] = b;
        tick;
        in_vld  = 1'b0;
    endtask

    task automatic test_reset;
        tick; tick;
        n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL rst_out_vld: got %b want 0", out_vld); end
        n_cmp++; if (out_dat !== '0) begin n_bad++; $display("FAIL rst_out_dat: got %h want 0", out_dat); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_err_ovf: got %b want 0", err_ovf); end
        rst_n = 1'b1;
        tick;
        n_cmp++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_in_rdy: got %b want 1", in_rdy); end
    endtask

    task automatic test_single;
        out_rdy = 1'b0;
        send(beat(0, 10, 1));
        tick; tick;
        n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL single_early: out_vld=%b want 0", out_vld); end
        tick;
        n_cmp++; if (out_vld !== 1'b1) begin n_bad++; $display("FAIL single_vld: out_vld=%b want 1", out_vld); end
        n_cmp++; if (out_dat !== row(0, 10, 1)) begin n_bad++; $display("FAIL single_dat: got %h want %h", out_dat, row(0, 10, 1)); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        tick;
        n_cmp++; if (out_vld !== 1'b1 || out_dat !== row(0, 10, 1)) begin n_bad++; $display("FAIL single_hold: vld=%b dat=%h want 1 %h", out_vld, out_dat, row(0, 10, 1)); end
        out_rdy = 1'b1; tick; out_rdy = 1'b0;
        n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL single_pop: out_vld=%b want 0", out_vld); end
    endtask

    task automatic test_accum;
        cfg_num_acc = 16'd3;
        tick;
        send(beat(5, 0, 0));
        send(beat(-2, 0, 0));
        send(beat(7, 0, 0));
        tick; tick;
        n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL accum_early: out_vld=%b want 0", out_vld); end
        tick;
        n_cmp++; if (out_vld !== 1'b1) begin n_bad++; $display("FAIL accum_vld: out_vld=%b want 1", out_vld); end
        n_cmp++; if (out_dat !== row(10, 0, 0)) begin n_bad++; $display("FAIL accum_dat: got %h want %h", out_dat, row(10, 0, 0)); end
        out_rdy = 1'b1; tick; out_rdy = 1'b0;
    endtask

    task automatic test_wrap;
        cfg_num_acc = 16'd2;
        tick;
        send(beat(-524288, 0, 0));
        send(beat(-524288, 0, 0));
        tick; tick; tick;
        n_cmp++; if (out_vld !== 1'b1 || out_dat !== row(-1048576, 0, 0)) begin n_bad++; $display("FAIL wrap_32: vld=%b dat=%h want 1 %h", out_vld, out_dat, row(-1048576, 0, 0)); end
        n_cmp++; if (out_vld_20 !== 1'b1 || out_dat_20 !== '0) begin n_bad++; $display("FAIL wrap_20: vld=%b dat=%h want 1 0", out_vld_20, out_dat_20); end
        out_rdy = 1'b1; tick; out_rdy = 1'b0;
    endtask

    task automatic test_backpressure;
        cfg_num_acc = 16'd1;
        tick;
        out_rdy = 1'b0;
        send(beat(100, 10, 1));
        send(beat(200, 10, 1));
        n_cmp++; if (in_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_in_rdy: got %b want 0", in_rdy); end
        in_vld = 1'b1; pipe[0] = beat(300, 10, 1); tick; in_vld = 1'b0;
        n_cmp++; if (err_ovf !== 1'b1) begin n_bad++; $display("FAIL bp_err_ovf: got %b want 1", err_ovf); end
        tick; tick; tick; tick;
        n_cmp++; if (out_vld !== 1'b1 || out_dat !== row(100, 10, 1)) begin n_bad++; $display("FAIL bp_row0: vld=%b dat=%h want 1 %h", out_vld, out_dat, row(100, 10, 1)); end
        out_rdy = 1'b1; tick; out_rdy = 1'b0;
        n_cmp++; if (out_vld !== 1'b1 || out_dat !== row(200, 10, 1)) begin n_bad++; $display("FAIL bp_row1: vld=%b dat=%h want 1 %h", out_vld, out_dat, row(200, 10, 1)); end
        n_cmp++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_in_rdy_free: got %b want 1", in_rdy); end
        out_rdy = 1'b1; tick; out_rdy = 1'b0;
        n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL bp_dropped: out_vld=%b want 0", out_vld); end
    endtask

    task automatic test_back_to_back;
        int w;
        rows_q.delete();
        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) send(beat(k * 100, 10, 1));
        w = 0;
        while (rows_q.size() < 8 && w < 100) begin
            tick;
            w++;
        end
        out_rdy = 1'b0;
        n_cmp++; if (rows_q.size() != 8) begin n_bad++; $display("FAIL b2b_count: got %0d rows want 8", rows_q.size()); end
        for (int k = 0; k < 8 && k < rows_q.size(); k++) begin
            n_cmp++;
            if (rows_q[k] !== row(k * 100, 10, 1)) begin
                n_bad++; $display("FAIL b2b_row%0d: got %h want %h", k, rows_q[k], row(k * 100, 10, 1));
            end
        end
    endtask

    task automatic test_reset_mid;
        cfg_num_acc = 16'd2;
        tick;
        out_rdy = 1'b0;
        send(beat(1, 0, 0));
        send(beat(2, 0, 0));
        tick; tick; tick; tick;
        n_cmp++; if (out_vld !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: out_vld=%b want 1", out_vld); end
        send(beat(9, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL rmid_vld: got %b want 0", out_vld); end
        n_cmp++; if (out_dat !== '0) begin n_bad++; $display("FAIL rmid_dat: got %h want 0", out_dat); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL rmid_err: got %b want 0", err_ovf); end
        tick;
        rst_n = 1'b1;
        tick;
        n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL rmid_post: out_vld=%b want 0", out_vld); end
        send(beat(1000, 2, 1));
        send(beat(-50, 4, 2));
        tick; tick;
        n_cmp++; if (out_vld !== 1'b0) begin n_bad++; $display("FAIL rmid_early: out_vld=%b want 0", out_vld); end
        tick;
        n_cmp++; if (out_vld !== 1'b1 || out_dat !== row(950, 6, 3)) begin n_bad++; $display("FAIL rmid_row: vld=%b dat=%h want 1 %h", out_vld, out_dat, row(950, 6, 3)); end
    endtask

    initial begin
        for (int s = 0; s < NCOL; s++) pipe[s] = '0;
        test_reset;
        test_single;
        test_accum;
        test_wrap;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
